// File: rtl/sad_best_select.sv
// sad_best_select: accumulates the per-line SAD of 25 quarter-pel candidates
// over LINES lines, then scans the totals for the minimum. The zero vector
// (candidate 12) wins all ties; among the other candidates the lowest index
// wins. The result is returned on a valid/ready output.
module sad_best_select #(
    parameter int LINES = 6,
    parameter int PIX   = 6,
    parameter int DW    = 8,
    parameter int SADW  = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [25*PIX*DW-1:0]    diff_flat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              best_idx,
    output logic [SADW-1:0]         best_sad,
    output logic [2:0]              mv_y,
    output logic [2:0]              mv_x
);

    localparam int LCW = (LINES > 1) ? $clog2(LINES) : 1;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_SCAN,
        ST_OUT
    } state_t;

    state_t            state_q,     state_d;
    logic [LCW-1:0]    line_cnt_q,  line_cnt_d;
    logic [4:0]        scan_step_q, scan_step_d;
    logic [4:0]        best_idx_q,  best_idx_d;
    logic [SADW-1:0]   best_sad_q,  best_sad_d;
    logic [SADW-1:0]   acc_q [25];
    logic [SADW-1:0]   acc_d [25];

    logic [SADW-1:0]   line_sum [25];
    logic [4:0]        cand_k;
    logic [SADW-1:0]   cand_sad;
    logic [2:0]        row;
    logic [2:0]        col;

    // Per-candidate sum of the PIX zero-extended differences on this line.
    always_comb begin
        for (int unsigned k = 0; k < 25; k++) begin
            line_sum[k] = '0;
            for (int unsigned p = 0; p < PIX; p++) begin
                line_sum[k] = line_sum[k] + SADW'(diff_flat[(k*PIX + p)*DW +: DW]);
            end
        end
    end

    // Scan order visits 12 first, then 0..11 and 13..24. With a strict
    // compare this gives the zero vector all ties, then the lowest index.
    always_comb begin
        if (scan_step_q == 5'd0) begin
            cand_k = 5'd12;
        end else if (scan_step_q <= 5'd12) begin
            cand_k = scan_step_q - 5'd1;
        end else begin
            cand_k = scan_step_q;
        end
        cand_sad = acc_q[cand_k];
    end

    // Next-state, accumulation, scan update and handshake outputs.
    always_comb begin
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        scan_step_d = scan_step_q;
        best_idx_d  = best_idx_q;
        best_sad_d  = best_sad_q;
        acc_d       = acc_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (state_q)
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int unsigned k = 0; k < 25; k++) begin
                        acc_d[k] = acc_q[k] + line_sum[k];
                    end
                    if (line_cnt_q == LCW'(LINES - 1)) begin
                        line_cnt_d  = '0;
                        scan_step_d = '0;
                        state_d     = ST_SCAN;
                    end else begin
                        line_cnt_d = line_cnt_q + LCW'(1);
                    end
                end
            end
            ST_SCAN: begin
                if ((scan_step_q == 5'd0) || (cand_sad < best_sad_q)) begin
                    best_idx_d = cand_k;
                    best_sad_d = cand_sad;
                end
                if (scan_step_q == 5'd24) begin
                    state_d = ST_OUT;
                end else begin
                    scan_step_d = scan_step_q + 5'd1;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    for (int unsigned k = 0; k < 25; k++) begin
                        acc_d[k] = '0;
                    end
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            line_cnt_q  <= '0;
            scan_step_q <= '0;
            best_idx_q  <= 5'd12;
            best_sad_q  <= '0;
            for (int unsigned k = 0; k < 25; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            scan_step_q <= scan_step_d;
            best_idx_q  <= best_idx_d;
            best_sad_q  <= best_sad_d;
            acc_q       <= acc_d;
        end
    end

    // Motion vector follows best_idx in the same cycle: row/col minus 2.
    always_comb begin
        row      = 3'(best_idx_q / 5'd5);
        col      = 3'(best_idx_q % 5'd5);
        mv_y     = row - 3'd2;
        mv_x     = col - 3'd2;
        best_idx = best_idx_q;
        best_sad = best_sad_q;
    end

endmodule

// File: tb/tb_sad_best_select.sv
// Directed bench for sad_best_select with a scoreboard of expected results.
module tb_sad_best_select;

    localparam int LINES = 6;
    localparam int PIX   = 6;
    localparam int DW    = 8;
    localparam int SADW  = 14;
    localparam int W     = 25*PIX*DW;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    diff_flat;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      best_idx;
    logic [SADW-1:0] best_sad;
    logic [2:0]      mv_y;
    logic [2:0]      mv_x;

    sad_best_select #(
        .LINES(LINES),
        .PIX  (PIX),
        .DW   (DW),
        .SADW (SADW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .diff_flat(diff_flat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .best_idx (best_idx),
        .best_sad (best_sad),
        .mv_y     (mv_y),
        .mv_x     (mv_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]      idx;
        logic [SADW-1:0] sad;
        logic [2:0]      my;
        logic [2:0]      mx;
    } exp_t;

    exp_t          sb [$];
    logic [W-1:0]  lines_v [LINES];
    int unsigned   cd [25];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int i = 0; i < 25*PIX; i++) v[i*DW +: DW] = DW'($urandom_range(0, 255));
        return v;
    endfunction

    // Every pixel of candidate k on every line equals cd[k].
    task automatic set_uniform();
        for (int l = 0; l < LINES; l++) begin
            for (int k = 0; k < 25; k++)
                for (int p = 0; p < PIX; p++)
                    lines_v[l][(k*PIX + p)*DW +: DW] = DW'(cd[k]);
        end
    endtask

    // Candidate k gets its whole total from one pixel on one line.
    task automatic set_single_totals();
        for (int l = 0; l < LINES; l++) lines_v[l] = '0;
        for (int k = 0; k < 25; k++)
            lines_v[k % LINES][(k*PIX + (k % PIX))*DW +: DW] = DW'(cd[k]);
    endtask

    task automatic set_random();
        for (int l = 0; l < LINES; l++) lines_v[l] = rand_vec();
    endtask

    // Reference: minimum total; 12 if it attains the minimum, else lowest index.
    task automatic push_expected();
        int unsigned tot [25];
        int unsigned m;
        int          best;
        exp_t        e;
        for (int k = 0; k < 25; k++) begin
            tot[k] = 0;
            for (int l = 0; l < LINES; l++)
                for (int p = 0; p < PIX; p++)
                    tot[k] += int'(lines_v[l][(k*PIX + p)*DW +: DW]);
        end
        m = tot[0];
        for (int k = 1; k < 25; k++) if (tot[k] < m) m = tot[k];
        best = -1;
        if (tot[12] == m) best = 12;
        for (int k = 0; k < 25; k++) if (best < 0 && tot[k] == m) best = k;
        e.idx = 5'(best);
        e.sad = SADW'(m);
        e.my  = 3'((best / 5) - 2);
        e.mx  = 3'((best % 5) - 2);
        sb.push_back(e);
    endtask

    // Presents one line; returns 1 time unit after its accepting edge.
    task automatic drive_line(input logic [W-1:0] v);
        in_valid  = 1'b1;
        diff_flat = v;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        diff_flat = rand_vec();
    endtask

    task automatic run_block(input int gap, input int stall, input bit junk);
        int   n;
        bit   ir_bad;
        bit   unstable;
        exp_t e;
        push_expected();
        for (int l = 0; l < LINES; l++) begin
            if (l > 0 && gap > 0) repeat (gap) begin @(posedge clk); #1; end
            check("in_ready_acc", 32'(in_ready), 32'd1);
            drive_line(lines_v[l]);
        end
        in_valid = junk;
        n = 0;
        ir_bad = 1'b0;
        while (n < 60) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) ir_bad = 1'b1;
            @(posedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd25);
        check("in_ready_scan", 32'(ir_bad), 32'd0);
        e = sb.pop_front();
        check("out_valid", 32'(out_valid), 32'd1);
        check("best_idx", 32'(best_idx), 32'(e.idx));
        check("best_sad", 32'(best_sad), 32'(e.sad));
        check("mv_y", 32'(mv_y), 32'(e.my));
        check("mv_x", 32'(mv_x), 32'(e.mx));
        unstable = 1'b0;
        repeat (stall) begin
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || in_ready || best_idx !== e.idx || best_sad !== e.sad ||
                mv_y !== e.my || mv_x !== e.mx) unstable = 1'b1;
        end
        check("stall_stable", 32'(unstable), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_best_idx", 32'(best_idx), 32'd12);
        check("rst_best_sad", 32'(best_sad), 32'd0);
        check("rst_mv_y", 32'(mv_y), 32'd0);
        check("rst_mv_x", 32'(mv_x), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        diff_flat = '0;
        @(negedge clk);
        apply_reset();

        // All zero: zero vector wins.
        for (int k = 0; k < 25; k++) cd[k] = 0;
        set_uniform();
        run_block(0, 0, 1'b0);

        // All ones except candidate 7.
        for (int k = 0; k < 25; k++) cd[k] = 1;
        cd[7] = 0;
        set_uniform();
        run_block(0, 0, 1'b0);

        // Tie between 3 and 20 -> lowest index.
        for (int k = 0; k < 25; k++) cd[k] = 50;
        cd[3] = 10; cd[20] = 10;
        set_single_totals();
        run_block(0, 0, 1'b0);

        // Zero vector joins the tie and wins.
        cd[12] = 10;
        set_single_totals();
        run_block(0, 0, 1'b0);

        // Full-scale totals without overflow.
        for (int k = 0; k < 25; k++) cd[k] = 255;
        set_uniform();
        run_block(0, 0, 1'b0);

        // Candidate 24 slightly smaller; also shows accumulators restart at 0.
        cd[24] = 254;
        set_uniform();
        run_block(0, 0, 1'b0);

        // Sparse input, junk during scan, long output stall.
        set_random();
        run_block(1, 10, 1'b1);

        // Reset after three lines discards the partial block.
        set_random();
        for (int l = 0; l < 3; l++) drive_line(lines_v[l]);
        @(negedge clk);
        apply_reset();
        set_random();
        run_block(0, 2, 1'b0);

        // Reset in the middle of the scan.
        set_random();
        for (int l = 0; l < LINES; l++) drive_line(lines_v[l]);
        repeat (10) @(posedge clk);
        @(negedge clk);
        apply_reset();
        for (int k = 0; k < 25; k++) cd[k] = 1;
        cd[7] = 0;
        set_uniform();
        run_block(0, 0, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sad_best_select.md
Name: sad_best_select

Overview:
- Sequential consumer of the per-line absolute-difference vectors that the sub-pixel difference datapath produces.
- Per block, accumulates the SAD of all 25 fractional candidates (5 rows UH/UQ/M/LQ/LH x 5 columns h/q/f/r/i) over LINES lines.
- After the last line, scans the 25 totals for the minimum and returns the winning index, quarter-pel motion vector and SAD on a valid/ready output.
- Sits between the difference datapath and the motion-vector writeback.

Parameters:
- LINES, 6, lines accumulated per block (inner 6x6 region).
- PIX, 6, pixels per line per candidate.
- DW, 8, bits per absolute difference.
- SADW, 14, accumulator width; must satisfy 2^SADW > LINES*PIX*(2^DW-1) (9180 at defaults).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  diff line present.
- in_ready  out  1  block accepts a line this cycle.
- diff_flat  in  25*PIX*DW  candidate k occupies bits [k*PIX*DW +: PIX*DW].
  - k = 5*row + col.
  - row: UH=0, UQ=1, M=2, LQ=3, LH=4.
  - col: h=0, q=1, f=2, r=3, i=4.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- best_idx  out  5  winning k (0..24).
- best_sad  out  SADW  winning SAD.
- mv_y  out  3  signed, row-2 (-2..+2 quarter pel).
- mv_x  out  3  signed, col-2 (-2..+2 quarter pel).

Behaviour:
- Reset (async, any state): state=ACC, line_cnt=0, all 25 accumulators=0, in_ready=1, out_valid=0, best_idx=12, best_sad=0, mv_y=0, mv_x=0.
- ACC state:
  - in_ready=1.
  - Accept on in_valid&&in_ready: for each k, acc[k] += zero-extended sum of its PIX diffs; line_cnt++.
  - When the accepted line is line LINES-1: line_cnt->0, state->SCAN, scan_step->0.
  - in_valid low: no change, no timeout.
- SCAN state:
  - in_ready=0; input ignored.
  - One candidate per cycle, order 12,0,1,..,11,13,..,24 (25 steps).
  - Step 0 loads best unconditionally from acc[12].
  - Later steps replace best only if acc[k] < best_sad (strict).
  - Net tie rule: zero vector (12) wins all ties; otherwise the lowest index wins.
  - After step 24: state->OUT.
- OUT state:
  - out_valid=1; best_idx/best_sad/mv_y/mv_x stable while out_valid&&!out_ready.
  - On out_valid&&out_ready: out_valid=0, all accumulators cleared, state->ACC. in_ready rises the next cycle.
- Latency: if the last line is accepted at edge E, out_valid is high after edge E+25. Throughput: one block per LINES+25+1 cycles minimum.
- Arithmetic: unsigned; no saturation needed given the SADW constraint. mv_y/mv_x are derived combinationally or registered from best_idx; either way they are consistent with best_idx in the same cycle.
- Outputs hold their last values in ACC; validity is signalled only by out_valid.
- Reset mid-block or mid-scan discards the partial block; the first accepted line after reset is line 0.

Test Plan:
- All diffs 0, 6 lines -> best_idx=12, best_sad=0, mv=(0,0); out_valid 25 cycles after the 6th accept.
- Every diff=1 except candidate 7 (UQ_f) diffs=0 -> best_idx=7, best_sad=0, mv_y=-1, mv_x=0; all others total 36.
- Candidates 3 and 20 both total 10, all others 50 including 12 -> best_idx=3. Then make 12 also total 10 -> best_idx=12.
- All diffs 255 on all 25 candidates -> best_sad=9180 with no overflow, best_idx=12. Then set candidate 24 diffs to 254 -> best_idx=24, best_sad=9144, mv=(+2,+2).
- in_valid toggled every other cycle; out_ready held low 10 cycles:
  - lines counted only on handshakes.
  - outputs stable while stalled.
  - in_ready=0 throughout SCAN/OUT.
  - the next block's accumulators start at 0.
- rst_n pulsed low after 3 lines and again mid-SCAN -> outputs return to reset values immediately; the following 6 fresh lines give the correct result.
